// File: rtl/oram_pkg.sv
// Shared types and constants for the OpenRAM request controller.
package oram_pkg;

  localparam int unsigned ORAM_ADDR_W  = 8;
  localparam int unsigned ORAM_DATA_W  = 32;
  localparam int unsigned ORAM_WMASK_W = ORAM_DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } oram_state_e;

  typedef struct packed {
    logic                    we;
    logic [ORAM_WMASK_W-1:0] wmask;
    logic [ORAM_ADDR_W-1:0]  addr;
    logic [ORAM_DATA_W-1:0]  wdata;
  } oram_req_t;

endpackage

// File: rtl/oram_rsp_fifo.sv
// Synchronous response FIFO; caller guarantees no push when full and no pop when empty.
module oram_rsp_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty_q, not_empty_d;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    not_empty_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      not_empty_q <= not_empty_d;
    end
  end

  assign pop_data  = mem_q[rd_ptr_q];
  assign not_empty = not_empty_q;
  assign count     = count_q;

endmodule

// File: rtl/oram_req_ctrl.sv
// Request controller for OpenRAM port 0: zero-fills the macro after reset, then
// issues core requests and returns read data in order under a credit rule.
module oram_req_ctrl
  import oram_pkg::*;
#(
  parameter int unsigned ADDR_W    = ORAM_ADDR_W,
  parameter int unsigned DATA_W    = ORAM_DATA_W,
  parameter int unsigned WMASK_W   = ORAM_WMASK_W,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic               oram_clk,
  input  logic               oram_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WMASK_W-1:0] req_wmask,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               init_done,
  output logic               oram_csb0,
  output logic               oram_web0,
  output logic [WMASK_W-1:0] oram_wmask0,
  output logic [ADDR_W-1:0]  oram_addr0,
  output logic [DATA_W-1:0]  oram_din0,
  input  logic [DATA_W-1:0]  oram_dout0
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OUT_W = CNT_W + 1;

  oram_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic               init_done_q, init_done_d;
  logic               req_ready_q, req_ready_d;
  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [WMASK_W-1:0] wmask_q, wmask_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;

  logic               accept_c;
  logic               push_c;
  logic               pop_c;
  logic               fifo_valid;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [OUT_W-1:0]   out_next_c;

  assign accept_c = req_valid && req_ready_q;
  assign push_c   = s2_q;
  assign pop_c    = fifo_valid && rsp_ready;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    csb_d       = 1'b1;
    web_d       = web_q;
    wmask_d     = wmask_q;
    addr_d      = addr_q;
    din_d       = din_q;
    s1_d        = 1'b0;
    s2_d        = s1_q;
    unique case (state_q)
      CLEAR: begin
        csb_d     = 1'b0;
        web_d     = 1'b0;
        wmask_d   = '1;
        addr_d    = clr_cnt_q;
        din_d     = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == '1) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (accept_c) begin
          csb_d   = 1'b0;
          web_d   = !req_we;
          wmask_d = req_wmask;
          addr_d  = req_addr;
          din_d   = req_wdata;
          s1_d    = !req_we;
        end
      end
      default: state_d = CLEAR;
    endcase
    // Credit is computed on next-cycle occupancy so req_ready can be a flop.
    out_next_c  = OUT_W'(s1_d) + OUT_W'(s2_d) + OUT_W'(fifo_cnt)
                + OUT_W'(push_c) - OUT_W'(pop_c);
    req_ready_d = (state_d == RUN) && (out_next_c < OUT_W'(RSP_DEPTH));
  end

  always_ff @(posedge oram_clk or posedge oram_rst) begin
    if (oram_rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      req_ready_q <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      req_ready_q <= req_ready_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

  oram_rsp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (oram_clk),
    .rst       (oram_rst),
    .push      (push_c),
    .push_data (oram_dout0),
    .pop       (pop_c),
    .pop_data  (rsp_rdata),
    .not_empty (fifo_valid),
    .count     (fifo_cnt)
  );

  assign req_ready   = req_ready_q;
  assign rsp_valid   = fifo_valid;
  assign init_done   = init_done_q;
  assign oram_csb0   = csb_q;
  assign oram_web0   = web_q;
  assign oram_wmask0 = wmask_q;
  assign oram_addr0  = addr_q;
  assign oram_din0   = din_q;

endmodule

// File: tb/tb_oram_req_ctrl.sv
// Bench for oram_req_ctrl: macro model, reference memory/response model, directed scenarios.
module tb_oram_req_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned DEPTH = 4;
  localparam int NWORDS = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          oram_csb0, oram_web0;
  logic [MW-1:0] oram_wmask0;
  logic [AW-1:0] oram_addr0;
  logic [DW-1:0] oram_din0;
  logic [DW-1:0] oram_dout0 = '0;

  always #5 clk = ~clk;

  oram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WMASK_W(MW), .RSP_DEPTH(DEPTH)) dut (
    .oram_clk(clk), .oram_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .oram_csb0(oram_csb0), .oram_web0(oram_web0), .oram_wmask0(oram_wmask0),
    .oram_addr0(oram_addr0), .oram_din0(oram_din0), .oram_dout0(oram_dout0)
  );

  // Macro model: registered command, masked write, registered read data, not reset.
  logic [DW-1:0] ram [NWORDS];
  initial for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;

  always @(posedge clk) begin
    if (!oram_csb0) begin
      if (!oram_web0) begin
        for (int b = 0; b < int'(MW); b++)
          if (oram_wmask0[b]) ram[oram_addr0][b*8 +: 8] <= oram_din0[b*8 +: 8];
      end else begin
        oram_dout0 <= ram[oram_addr0];
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: zero-filled memory, queue of owed read data, cycles since release.
  int            rel_cycles = 0;
  logic [DW-1:0] shadow [NWORDS];
  logic [DW-1:0] exp_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_cycles = 0;
      exp_q.delete();
      for (int i = 0; i < NWORDS; i++) shadow[i] = '0;
    end else begin
      rel_cycles++;
      if (req_valid && req_ready) begin
        if (req_we) begin
          for (int b = 0; b < int'(MW); b++)
            if (req_wmask[b]) shadow[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end else begin
          exp_q.push_back(shadow[req_addr]);
        end
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("init_done", init_done, rel_cycles >= NWORDS);
      check("req_ready", req_ready, (rel_cycles >= NWORDS) && (exp_q.size() < int'(DEPTH)));
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_valid_unowed", rsp_valid, 1'b0);
        else check("rsp_rdata", rsp_rdata, exp_q[0]);
      end
    end
  end

  task automatic clear_seq(input string name);
    logic [46:0] exp;
    for (int k = 0; k < NWORDS; k++) begin
      @(posedge clk); #1;
      exp = {1'b0, 1'b0, 4'hF, 8'(k), 32'h0, 1'(k == NWORDS - 1)};
      check(name, {oram_csb0, oram_web0, oram_wmask0, oram_addr0, oram_din0, init_done}, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    while (!acc && waits < 50) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk);
      if (!acc) waits++;
    end
    if (!acc) check("req_accept_timeout", acc, 1'b1);
    #1; req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [DW-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check({name, "_valid"}, rsp_valid, 1'b1);
    check(name, rsp_rdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wsum, acc_n;
    logic r;
    req_valid = 0; req_we = 0; req_wmask = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {req_ready, rsp_valid, rsp_rdata, init_done}, '0);
    check("rst_pins", {oram_csb0, oram_web0, oram_wmask0, oram_addr0, oram_din0},
          {1'b1, 1'b1, 4'h0, 8'h00, 32'h0});
    rst = 1'b0;
    clear_seq("clear1");
    @(posedge clk); #1;
    check("idle_csb", oram_csb0, 1'b1);

    do_req(1'b0, 8'hA7, '0, '0, w);
    wait_rsp("rd_a7", 32'h0000_0000);

    // Write then read with exact two-cycle latency.
    do_req(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, w);
    do_req(1'b0, 8'h10, '0, '0, w);
    @(posedge clk); #1;
    check("lat_n1_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_n2_valid", rsp_valid, 1'b1);
    check("lat_n2_data", rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    do_req(1'b1, 8'h10, 32'h1122_3344, 4'h5, w);
    do_req(1'b0, 8'h10, '0, '0, w);
    wait_rsp("rd_mask5", 32'hDE22_BE44);

    // Throughput: prewrite 0..7, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) do_req(1'b1, AW'(i), DW'(i), 4'hF, w);
    wsum = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          do_req(1'b0, AW'(i), '0, '0, w);
          wsum += w;
        end
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
        for (int k = 0; k < 8; k++) begin
          check("thru_rsp", {rsp_valid, rsp_rdata}, {1'b1, DW'(k)});
          @(negedge clk);
        end
      end
    join
    check("thru_no_stall", 64'(wsum), 64'd0);
    @(posedge clk); #1;

    // Backpressure: exactly RSP_DEPTH reads accepted with the consumer stalled.
    rsp_ready = 1'b0;
    acc_n = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1;
      if (r) begin acc_n++; req_addr = AW'(acc_n); end
    end
    req_valid = 1'b0;
    check("bp_accepted", 64'(acc_n), 64'd4);
    check("bp_ready_low", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_rsp", {rsp_valid, rsp_rdata}, {1'b1, DW'(k)});
      if (k == 0) check("bp_no_lend", req_ready, 1'b0);
      if (k == 1) check("bp_credit_back", req_ready, 1'b1);
    end
    @(posedge clk); #1;

    // Reset with one response queued and two reads in flight.
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h06, '0, '0, w);
    do_req(1'b0, 8'h05, '0, '0, w);
    do_req(1'b0, 8'h04, '0, '0, w);
    check("mid_pre_valid", rsp_valid, 1'b1);
    check("mid_pre_csb", oram_csb0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {rsp_valid, init_done, oram_csb0, req_ready}, {1'b0, 1'b0, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    clear_seq("clear2");
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_stale", rsp_valid, 1'b0);
    do_req(1'b0, 8'h06, '0, '0, w);
    wait_rsp("post_rst_rd", 32'h0000_0000);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
